conv_window_sequencer: RTL and testbench

- Sequences one convolution layer of the digit-recognition CNN.
- Walks every output pixel of a valid (no-padding, stride-1) convolution. For each pixel it issues image-RAM and kernel-ROM read addresses, drives the shared MAC's clear and accumulate strobes, and writes the result to the layer output RAM.
- Sits between the top-level layer controller (start/done handshake) and the MAC datapath and its memories.

---
 rtl/conv_window_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_conv_window_sequencer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sequencer.sv
`timescale 1ns/1ps
// conv_window_sequencer
//   Sequences one valid (no padding, stride 1) convolution layer. For every
//   output pixel it clears the MAC, streams K*K image/kernel reads, waits for
//   the read pipeline to drain, then writes the accumulated result.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   start, abort        run request (accepted in IDLE only), cancel run
//   busy, done          not-IDLE flag, one-cycle completion pulse
//   in_addr, in_rd      image RAM read address / read strobe (shared w/ ROM)
//   k_addr              kernel ROM read address
//   mac_clr, mac_en     MAC clear, MAC accumulate (in_rd delayed by MEM_LAT)
//   out_addr, out_we    output RAM write address / write strobe
//   cycle_count         (CONV_SEQ_PERF_EN only) cycles spent busy in last run
//
// Build option
//   CONV_SEQ_PERF_EN    adds the 32-bit cycle_count performance counter.
module conv_window_sequencer #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int K       = 5,
  parameter int MEM_LAT = 1,
  parameter int IN_AW   = 10,
  parameter int K_AW    = 5,
  parameter int OUT_AW  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [IN_AW-1:0]  in_addr,
  output logic              in_rd,
  output logic [K_AW-1:0]   k_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [OUT_AW-1:0] out_addr,
  output logic              out_we
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0]       cycle_count
`endif
);

  localparam int OW  = IMG_W - K + 1;
  localparam int OH  = IMG_H - K + 1;
  localparam int OXW = (OW > 1) ? $clog2(OW) : 1;
  localparam int OYW = (OH > 1) ? $clog2(OH) : 1;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int DW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE, CLEAR, ACCUM, DRAIN, WRITE, DONE
  } state_t;

  state_t           state;
  logic [OXW-1:0]   ox;
  logic [OYW-1:0]   oy;
  logic [KW-1:0]    kx, ky;
  logic [DW-1:0]    dcnt;

  // Registered strobes before abort gating.
  logic             in_rd_q, mac_clr_q, out_we_q, done_q;
  // Read-valid delay line; stage MEM_LAT lines up with returned read data.
  logic [MEM_LAT:1] vld_pipe;

  // Next-tap values and the addresses they map to.
  logic             k_wrap, last_tap;
  logic [KW-1:0]    nkx, nky;
  logic [IN_AW-1:0] nxt_in_addr, base_in_addr;
  logic [K_AW-1:0]  nxt_k_addr;
  logic [OUT_AW-1:0] pix_out_addr;
  logic             kill;

  assign busy = (state != IDLE);
  // Abort takes effect combinationally so no strobe escapes in the abort cycle.
  assign kill = abort && busy;

  assign in_rd   = in_rd_q   & ~kill;
  assign mac_clr = mac_clr_q & ~kill;
  assign out_we  = out_we_q  & ~kill;
  assign done    = done_q    & ~kill;
  assign mac_en  = vld_pipe[MEM_LAT] & ~kill;

  // All address products are formed at 32 bits and only truncated at the end.
  always_comb begin
    k_wrap       = (kx == KW'(K - 1));
    last_tap     = k_wrap && (ky == KW'(K - 1));
    nkx          = k_wrap ? '0 : kx + 1'b1;
    nky          = k_wrap ? ky + 1'b1 : ky;
    nxt_in_addr  = IN_AW'((32'(oy) + 32'(nky)) * 32'(IMG_W) + 32'(ox) + 32'(nkx));
    base_in_addr = IN_AW'(32'(oy) * 32'(IMG_W) + 32'(ox));
    nxt_k_addr   = K_AW'(32'(nky) * 32'(K) + 32'(nkx));
    pix_out_addr = OUT_AW'(32'(oy) * 32'(OW) + 32'(ox));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ox        <= '0;
      oy        <= '0;
      kx        <= '0;
      ky        <= '0;
      dcnt      <= '0;
      in_rd_q   <= 1'b0;
      mac_clr_q <= 1'b0;
      out_we_q  <= 1'b0;
      done_q    <= 1'b0;
      in_addr   <= '0;
      k_addr    <= '0;
      out_addr  <= '0;
      vld_pipe  <= '0;
    end else if (kill) begin
      state     <= IDLE;
      ox        <= '0;
      oy        <= '0;
      kx        <= '0;
      ky        <= '0;
      dcnt      <= '0;
      in_rd_q   <= 1'b0;
      mac_clr_q <= 1'b0;
      out_we_q  <= 1'b0;
      done_q    <= 1'b0;
      in_addr   <= '0;
      k_addr    <= '0;
      out_addr  <= '0;
      vld_pipe  <= '0;
    end else begin
      // Delay line runs in every state so the tail of ACCUM drains in DRAIN.
      vld_pipe[1] <= in_rd_q;
      for (int i = 2; i <= MEM_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];

      mac_clr_q <= 1'b0;
      out_we_q  <= 1'b0;
      done_q    <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= CLEAR;
            mac_clr_q <= 1'b1;
            ox        <= '0;
            oy        <= '0;
          end
        end
        CLEAR: begin
          kx      <= '0;
          ky      <= '0;
          in_rd_q <= 1'b1;
          in_addr <= base_in_addr;
          k_addr  <= '0;
          state   <= ACCUM;
        end
        ACCUM: begin
          if (last_tap) begin
            in_rd_q <= 1'b0;
            in_addr <= '0;
            k_addr  <= '0;
            kx      <= '0;
            ky      <= '0;
            dcnt    <= '0;
            state   <= DRAIN;
          end else begin
            kx      <= nkx;
            ky      <= nky;
            in_addr <= nxt_in_addr;
            k_addr  <= nxt_k_addr;
          end
        end
        DRAIN: begin
          if (dcnt == DW'(MEM_LAT - 1)) begin
            out_we_q <= 1'b1;
            out_addr <= pix_out_addr;
            state    <= WRITE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        WRITE: begin
          out_addr <= '0;
          if (ox != OXW'(OW - 1)) begin
            ox        <= ox + 1'b1;
            mac_clr_q <= 1'b1;
            state     <= CLEAR;
          end else if (oy != OYW'(OH - 1)) begin
            ox        <= '0;
            oy        <= oy + 1'b1;
            mac_clr_q <= 1'b1;
            state     <= CLEAR;
          end else begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          ox    <= '0;
          oy    <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONV_SEQ_PERF_EN
  // Cleared on an accepted start, counts busy cycles, holds once idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cycle_count <= '0;
    else if (!busy && start && !abort)
      cycle_count <= '0;
    else if (busy)
      cycle_count <= cycle_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_conv_window_sequencer.sv
`timescale 1ns/1ps
module tb_conv_window_sequencer;

  localparam int NREC = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: 4x4, K=3, MEM_LAT=1
  logic       a_start, a_abort, a_busy, a_done, a_in_rd, a_mac_clr, a_mac_en, a_out_we;
  logic [9:0] a_in_addr, a_out_addr;
  logic [4:0] a_k_addr;
  // DUT B: defaults
  logic       b_start, b_abort, b_busy, b_done, b_in_rd, b_mac_clr, b_mac_en, b_out_we;
  logic [9:0] b_in_addr, b_out_addr;
  logic [4:0] b_k_addr;
  // DUT C: 4x4, K=3, MEM_LAT=3
  logic       c_start, c_abort, c_busy, c_done, c_in_rd, c_mac_clr, c_mac_en, c_out_we;
  logic [9:0] c_in_addr, c_out_addr;
  logic [4:0] c_k_addr;
`ifdef CONV_SEQ_PERF_EN
  logic [31:0] a_cc, b_cc, c_cc;
`endif

  conv_window_sequencer #(.IMG_W(4), .IMG_H(4), .K(3), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .abort(a_abort), .busy(a_busy), .done(a_done),
    .in_addr(a_in_addr), .in_rd(a_in_rd), .k_addr(a_k_addr), .mac_clr(a_mac_clr),
    .mac_en(a_mac_en), .out_addr(a_out_addr), .out_we(a_out_we)
`ifdef CONV_SEQ_PERF_EN
    , .cycle_count(a_cc)
`endif
  );

  conv_window_sequencer dut_b (
    .clk(clk), .reset(reset), .start(b_start), .abort(b_abort), .busy(b_busy), .done(b_done),
    .in_addr(b_in_addr), .in_rd(b_in_rd), .k_addr(b_k_addr), .mac_clr(b_mac_clr),
    .mac_en(b_mac_en), .out_addr(b_out_addr), .out_we(b_out_we)
`ifdef CONV_SEQ_PERF_EN
    , .cycle_count(b_cc)
`endif
  );

  conv_window_sequencer #(.IMG_W(4), .IMG_H(4), .K(3), .MEM_LAT(3)) dut_c (
    .clk(clk), .reset(reset), .start(c_start), .abort(c_abort), .busy(c_busy), .done(c_done),
    .in_addr(c_in_addr), .in_rd(c_in_rd), .k_addr(c_k_addr), .mac_clr(c_mac_clr),
    .mac_en(c_mac_en), .out_addr(c_out_addr), .out_we(c_out_we)
`ifdef CONV_SEQ_PERF_EN
    , .cycle_count(c_cc)
`endif
  );

  // Per-cycle records; cycle 0 is the cycle in which start is presented.
  logic [NREC-1:0] ra_busy, ra_done, ra_rd, ra_en, ra_clr, ra_we;
  logic [9:0]      ra_ia [NREC];
  logic [4:0]      ra_ka [NREC];
  logic [9:0]      ra_oa [NREC];
  logic [NREC-1:0] rc_busy, rc_done, rc_rd, rc_en, rc_we;
  logic [9:0]      rc_oa [NREC];

  // Window taps of pixel (0,0) on a 4-wide image with K=3.
  int exp_ia [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_ac(input bit go_a, input bit go_c);
    a_start = go_a;
    c_start = go_c;
    for (int c = 0; c < NREC; c++) begin
      @(negedge clk);
      ra_busy[c] = a_busy;  ra_done[c] = a_done;  ra_rd[c] = a_in_rd;
      ra_en[c]   = a_mac_en; ra_clr[c] = a_mac_clr; ra_we[c] = a_out_we;
      ra_ia[c]   = a_in_addr; ra_ka[c] = a_k_addr; ra_oa[c] = a_out_addr;
      rc_busy[c] = c_busy;  rc_done[c] = c_done;  rc_rd[c] = c_in_rd;
      rc_en[c]   = c_mac_en; rc_we[c] = c_out_we; rc_oa[c] = c_out_addr;
      @(posedge clk); #1;
      a_start = 1'b0;
      c_start = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_start = 0; a_abort = 0; b_start = 0; b_abort = 0; c_start = 0; c_abort = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_in_rd, a_mac_clr, a_mac_en, a_out_we} !== 6'b0) begin
      errors++; $display("FAIL reset_a_strobes got %b exp 000000",
        {a_busy, a_done, a_in_rd, a_mac_clr, a_mac_en, a_out_we});
    end
    checks++;
    if ({a_in_addr, a_k_addr, a_out_addr} !== 25'd0) begin
      errors++; $display("FAIL reset_a_addr got %h/%h/%h exp 0", a_in_addr, a_k_addr, a_out_addr);
    end
    checks++;
    if ({b_busy, b_done, b_in_rd, b_mac_clr, b_mac_en, b_out_we, b_in_addr, b_k_addr, b_out_addr} !== 31'd0) begin
      errors++; $display("FAIL reset_b got nonzero outputs exp 0");
    end
    checks++;
    if ({c_busy, c_done, c_in_rd, c_mac_clr, c_mac_en, c_out_we, c_in_addr, c_k_addr, c_out_addr} !== 31'd0) begin
      errors++; $display("FAIL reset_c got nonzero outputs exp 0");
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_busy, b_busy, c_busy} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset busy got %b exp 000", {a_busy, b_busy, c_busy});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_first_pixel();
    run_ac(1'b1, 1'b1);
    checks++;
    if (ra_clr[1] !== 1'b1 || ra_clr[0] !== 1'b0 || ra_clr[2] !== 1'b0) begin
      errors++; $display("FAIL mac_clr_c1 got %b exp 010", ra_clr[2:0]);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (ra_rd[2+i] !== 1'b1 || ra_ia[2+i] !== 10'(exp_ia[i]) || ra_ka[2+i] !== 5'(i)) begin
        errors++; $display("FAIL tap%0d got rd=%b ia=%0d ka=%0d exp rd=1 ia=%0d ka=%0d",
          i, ra_rd[2+i], ra_ia[2+i], ra_ka[2+i], exp_ia[i], i);
      end
      checks++;
      if (ra_en[3+i] !== 1'b1) begin
        errors++; $display("FAIL mac_en_tap%0d got %b exp 1", i, ra_en[3+i]);
      end
    end
    checks++;
    if (ra_rd[11] !== 1'b0 || ra_en[2] !== 1'b0 || ra_en[12] !== 1'b0) begin
      errors++; $display("FAIL edges got rd11=%b en2=%b en12=%b exp 000", ra_rd[11], ra_en[2], ra_en[12]);
    end
    checks++;
    if (ra_we[12] !== 1'b1 || ra_oa[12] !== 10'd0 || ra_we[11] !== 1'b0) begin
      errors++; $display("FAIL write0 got we12=%b oa=%0d we11=%b exp 1 0 0", ra_we[12], ra_oa[12], ra_we[11]);
    end
    for (int c = 0; c < NREC; c++) begin
      checks++;
      if (ra_done[c] !== (c == 49) || ra_busy[c] !== (c >= 1 && c <= 49)) begin
        errors++; $display("FAIL done_busy_c%0d got done=%b busy=%b exp %b %b",
          c, ra_done[c], ra_busy[c], (c == 49), (c >= 1 && c <= 49));
      end
    end
  endtask

  task automatic test_pixels();
    int nwe;
    checks++;
    if (ra_ia[14] !== 10'd1 || ra_ia[22] !== 10'd11 || ra_we[24] !== 1'b1 || ra_oa[24] !== 10'd1) begin
      errors++; $display("FAIL pixel1 got ia=%0d..%0d we=%b oa=%0d exp 1..11 1 1",
        ra_ia[14], ra_ia[22], ra_we[24], ra_oa[24]);
    end
    checks++;
    if (ra_ia[26] !== 10'd4 || ra_we[36] !== 1'b1 || ra_oa[36] !== 10'd2) begin
      errors++; $display("FAIL pixel2 got ia=%0d we=%b oa=%0d exp 4 1 2", ra_ia[26], ra_we[36], ra_oa[36]);
    end
    checks++;
    if (ra_ia[38] !== 10'd5 || ra_ia[46] !== 10'd15 || ra_we[48] !== 1'b1 || ra_oa[48] !== 10'd3) begin
      errors++; $display("FAIL pixel3 got ia=%0d..%0d we=%b oa=%0d exp 5..15 1 3",
        ra_ia[38], ra_ia[46], ra_we[48], ra_oa[48]);
    end
    nwe = 0;
    for (int c = 0; c < NREC; c++) begin
      if (ra_we[c] === 1'b1) nwe++;
      checks++;
      if ((int'(ra_clr[c]) + int'(ra_we[c]) + int'(ra_done[c])) > 1 || (ra_clr[c] && ra_en[c])) begin
        errors++; $display("FAIL exclusive_c%0d got clr=%b we=%b done=%b en=%b",
          c, ra_clr[c], ra_we[c], ra_done[c], ra_en[c]);
      end
    end
    checks++;
    if (nwe != 4) begin
      errors++; $display("FAIL we_count got %0d exp 4", nwe);
    end
  endtask

  task automatic test_mem_lat3();
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (rc_rd[c] !== (c >= 2 && c <= 10) || rc_en[c] !== (c >= 5 && c <= 13)) begin
        errors++; $display("FAIL lat3_c%0d got rd=%b en=%b exp %b %b",
          c, rc_rd[c], rc_en[c], (c >= 2 && c <= 10), (c >= 5 && c <= 13));
      end
    end
    checks++;
    if (rc_we[14] !== 1'b1 || rc_oa[14] !== 10'd0 || rc_we[28] !== 1'b1 || rc_oa[28] !== 10'd1) begin
      errors++; $display("FAIL lat3_writes got we14=%b oa=%0d we28=%b oa=%0d exp 1 0 1 1",
        rc_we[14], rc_oa[14], rc_we[28], rc_oa[28]);
    end
    for (int c = 50; c < NREC; c++) begin
      checks++;
      if (rc_done[c] !== (c == 57) || rc_busy[c] !== (c <= 57)) begin
        errors++; $display("FAIL lat3_done_c%0d got done=%b busy=%b exp %b %b",
          c, rc_done[c], rc_busy[c], (c == 57), (c <= 57));
      end
    end
  endtask

  task automatic test_abort();
    int ndone;
    ndone = 0;
    a_start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 20) a_abort = 1'b1;
      @(negedge clk);
      if (a_done === 1'b1) ndone++;
      if (c == 20) begin
        checks++;
        if ({a_in_rd, a_mac_en, a_mac_clr, a_out_we, a_done} !== 5'b0) begin
          errors++; $display("FAIL abort_same_cycle got %b exp 00000",
            {a_in_rd, a_mac_en, a_mac_clr, a_out_we, a_done});
        end
      end
      if (c == 21) begin
        checks++;
        if ({a_busy, a_in_rd, a_mac_en, a_mac_clr, a_out_we, a_done} !== 6'b0) begin
          errors++; $display("FAIL abort_next_cycle got %b exp 000000",
            {a_busy, a_in_rd, a_mac_en, a_mac_clr, a_out_we, a_done});
        end
      end
      @(posedge clk); #1;
      a_start = 1'b0;
      a_abort = 1'b0;
    end
    checks++;
    if (ndone != 0) begin
      errors++; $display("FAIL abort_no_done got %0d exp 0", ndone);
    end
    run_ac(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (ra_rd[2+i] !== 1'b1 || ra_ia[2+i] !== 10'(exp_ia[i])) begin
        errors++; $display("FAIL rerun_tap%0d got rd=%b ia=%0d exp 1 %0d", i, ra_rd[2+i], ra_ia[2+i], exp_ia[i]);
      end
    end
    checks++;
    if (ra_we[12] !== 1'b1 || ra_done[49] !== 1'b1 || ra_busy[50] !== 1'b0) begin
      errors++; $display("FAIL rerun_end got we12=%b done49=%b busy50=%b exp 1 1 0",
        ra_we[12], ra_done[49], ra_busy[50]);
    end
  endtask

  task automatic test_reset_mid();
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    checks++;
    if (a_in_rd !== 1'b1) begin
      errors++; $display("FAIL pre_reset_accum got rd=%b exp 1", a_in_rd);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({a_busy, a_in_rd, a_mac_en, a_mac_clr, a_out_we, a_done, a_in_addr, a_k_addr} !== 21'd0) begin
      errors++; $display("FAIL async_reset got busy=%b rd=%b ia=%0d ka=%0d exp all 0",
        a_busy, a_in_rd, a_in_addr, a_k_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    run_ac(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (ra_ia[2+i] !== 10'(exp_ia[i]) || ra_ka[2+i] !== 5'(i)) begin
        errors++; $display("FAIL post_reset_tap%0d got ia=%0d ka=%0d exp %0d %0d",
          i, ra_ia[2+i], ra_ka[2+i], exp_ia[i], i);
      end
    end
    checks++;
    if (ra_done[49] !== 1'b1 || ra_busy[50] !== 1'b0) begin
      errors++; $display("FAIL post_reset_done got %b %b exp 1 0", ra_done[49], ra_busy[50]);
    end
  endtask

  task automatic test_start_while_busy();
    int nwe, dcyc;
    nwe = 0; dcyc = -1;
    a_start = 1'b1;
    for (int c = 0; c < 56; c++) begin
      @(negedge clk);
      if (a_out_we === 1'b1) nwe++;
      if (a_done === 1'b1) dcyc = c;
      if (c == 52) begin
        checks++;
        if (a_busy !== 1'b0) begin
          errors++; $display("FAIL start_in_done_ignored got busy=%b exp 0", a_busy);
        end
      end
      @(posedge clk); #1;
      a_start = (c == 9 || c == 29 || c == 48);
    end
    a_start = 1'b0;
    checks++;
    if (nwe != 4 || dcyc != 49) begin
      errors++; $display("FAIL start_while_busy got we=%0d done_cycle=%0d exp 4 49", nwe, dcyc);
    end
  endtask

`ifdef CONV_SEQ_PERF_EN
  task automatic test_perf();
    @(negedge clk);
    checks++;
    if (a_cc !== 32'd49) begin
      errors++; $display("FAIL perf_after_done got %0d exp 49", a_cc);
    end
    @(posedge clk); #1;
    a_start = 1'b1;
    @(negedge clk);
    checks++;
    if (a_cc !== 32'd49) begin
      errors++; $display("FAIL perf_held got %0d exp 49", a_cc);
    end
    @(posedge clk); #1;
    a_start = 1'b0;
    @(negedge clk);
    checks++;
    if (a_cc !== 32'd0) begin
      errors++; $display("FAIL perf_cleared got %0d exp 0", a_cc);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_abort = 1'b1;
    @(posedge clk); #1;
    a_abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_cc !== 32'd3 || a_busy !== 1'b0) begin
      errors++; $display("FAIL perf_after_abort got %0d busy=%b exp 3 0", a_cc, a_busy);
    end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_defaults();
    int nwe, last_oa, max_ia, dcyc;
    nwe = 0; last_oa = -1; max_ia = 0; dcyc = -1;
    b_start = 1'b1;
    for (int c = 0; c < 17000; c++) begin
      @(negedge clk);
      if (b_out_we === 1'b1) begin nwe++; last_oa = int'(b_out_addr); end
      if (b_in_rd === 1'b1 && int'(b_in_addr) > max_ia) max_ia = int'(b_in_addr);
      if (b_done === 1'b1) begin dcyc = c; break; end
      @(posedge clk); #1;
      b_start = 1'b0;
    end
    @(posedge clk); #1;
    b_start = 1'b0;
    checks++;
    if (dcyc != 16129) begin
      errors++; $display("FAIL default_done_cycle got %0d exp 16129", dcyc);
    end
    checks++;
    if (nwe != 576 || last_oa != 575) begin
      errors++; $display("FAIL default_writes got %0d last=%0d exp 576 575", nwe, last_oa);
    end
    checks++;
    if (max_ia != 783) begin
      errors++; $display("FAIL default_max_in_addr got %0d exp 783", max_ia);
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_pixels();
    test_mem_lat3();
    test_abort();
    test_reset_mid();
    test_start_while_busy();
`ifdef CONV_SEQ_PERF_EN
    test_perf();
`endif
    test_defaults();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
